dbus_walk_arbiter: RTL
======================

DBUS_WALK_ARBITER -- requirements
Module: dbus_walk_arbiter

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 clk  input  1  clock; all state updates on posedge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 ptw_req  input  dbus_req_t  request from the page-table walker (DataMMU).
REQ-005 ptw_resp  output  dbus_resp_t  response routed to the walker.
REQ-006 mem_req  input  dbus_req_t  request from the load/store stage.
REQ-007 mem_resp  output  dbus_resp_t  response routed to the load/store stage.
REQ-008 dreq  output  dbus_req_t  single request toward the shared dBUS.
REQ-009 dresp  input  dbus_resp_t  response from the shared dBUS.
REQ-010 owner  output  2  current grant: 00 none, 01 PTW, 10 MEM.

Function
REQ-011 The FSM SHALL have three states: IDLE, BUSY_PTW and BUSY_MEM.
REQ-012 In IDLE with at least one requester valid, the block SHALL latch the winner's whole request (valid, strobe, size, addr, data) on that edge and enter BUSY_<winner>.
- Arbitration latency: exactly 1 cycle.
REQ-013 In IDLE, dreq.valid SHALL be 0.
REQ-014 In BUSY_x, dreq SHALL equal the latched request with valid=1, held stable until dresp.data_ok, independent of later changes on ptw_req or mem_req.
REQ-015 In BUSY_x, x_resp SHALL mirror dresp combinationally (addr_ok, data_ok, data).
REQ-016 The non-owner's resp SHALL have addr_ok=0 and data_ok=0, with data=0.
REQ-017 In BUSY_x, a cycle with dresp.data_ok=1 SHALL return the FSM to IDLE on the next edge.
- No new grant in that same cycle.
- Minimum spacing between two bus transactions: 1 IDLE cycle.
REQ-018 If the owner drops valid while in BUSY_x, the transaction SHALL NOT be aborted.
- The latched request is driven until data_ok.
- The response is still routed to x.
REQ-019 In IDLE, dresp.data_ok=1 is ignored: neither requester sees it.
REQ-020 A requester that loses arbitration SHALL see no data_ok and SHALL be granted no later than the second IDLE cycle after the current transaction completes, provided it holds valid.
- Bounded wait is guaranteed only with RR enabled, or when the requester is PTW.
REQ-021 Simultaneous requests in IDLE SHALL be resolved per REQ-026/REQ-027.
REQ-022 The last_served register (1 bit: 0 PTW, 1 MEM) SHALL update on every grant.
REQ-023 owner SHALL be a registered encoding of the FSM state.

Reset
REQ-024 Reset SHALL take effect on the next edge regardless of state, including mid-transaction. Resulting values:
- state IDLE, owner=00, latched request cleared, last_served=1 (MEM).
- dreq.valid=0 from the first cycle after reset.
- Both resp outputs carry data_ok=0.
REQ-025 A dresp.data_ok arriving in the cycle after reset SHALL be dropped.

Configuration
REQ-026 With DBUS_ARB_RR_EN defined, simultaneous requests SHALL be granted to the requester that is not last_served (round-robin).
REQ-027 With DBUS_ARB_RR_EN undefined, simultaneous requests SHALL always go to PTW (fixed priority); last_served is still maintained but unused.

Verification
REQ-028 Directed scenarios (dBUS model returns data_ok 3 cycles after valid):
- Single MEM load at addr 0x8000_0010, size MSIZE8 -> dreq.valid rises 1 cycle later, mem_resp.data_ok pulses once with the model data, ptw_resp.data_ok stays 0, owner 10 then 00.
- PTW and MEM valid in the same IDLE cycle, RR undefined -> PTW is served first; MEM is granted 1 cycle after PTW's data_ok; ptw_req.addr is observed on dreq first.
- Same stimulus, RR defined, after reset -> PTW is served first; next simultaneous pair -> MEM served first.
- MEM store (strobe 8'hFF, addr 0x100) drops valid 1 cycle after grant -> dreq stays valid with addr 0x100 and strobe FF until data_ok; mem_resp.data_ok pulses.
- Reset asserted in BUSY_PTW, 1 cycle before data_ok -> owner=00, dreq.valid=0, and the late data_ok reaches neither requester.
- PTW re-requests continuously, RR defined, MEM waiting -> MEM is granted within 2 IDLE cycles (no starvation).

Source files
------------

// File: rtl/dbus_walk_arbiter_if.sv
// Shared dBUS request/response types and the arbiter's bus-side interface.
// Carries both requester channels, the shared bus channel and the owner code.
typedef enum logic [1:0] {MSIZE1, MSIZE2, MSIZE4, MSIZE8} dbus_size_t;

typedef struct packed {
    logic       valid;
    logic [7:0] strobe;
    dbus_size_t size;
    logic [31:0] addr;
    logic [63:0] data;
} dbus_req_t;

typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
} dbus_resp_t;

interface dbus_walk_arbiter_if;
    dbus_req_t  ptw_req;
    dbus_req_t  mem_req;
    dbus_req_t  dreq;
    dbus_resp_t ptw_resp;
    dbus_resp_t mem_resp;
    dbus_resp_t dresp;
    logic [1:0] owner;

    modport master (
        input  ptw_req, mem_req, dresp,
        output ptw_resp, mem_resp, dreq, owner
    );
    modport slave (
        output ptw_req, mem_req, dresp,
        input  ptw_resp, mem_resp, dreq, owner
    );
endinterface

// File: rtl/dbus_walk_arbiter.sv
// Two-way arbiter sharing one dBUS between the page-table walker and load/store.
// Define DBUS_ARB_RR_EN for round-robin on simultaneous requests; default is PTW priority.
module dbus_walk_arbiter (
    input  logic clk,
    input  logic reset,
    dbus_walk_arbiter_if.master bus
);
    localparam logic [1:0] IDLE     = 2'b00;
    localparam logic [1:0] BUSY_PTW = 2'b01;
    localparam logic [1:0] BUSY_MEM = 2'b10;

    logic [1:0] state;
    dbus_req_t  latched;
    logic       last_served;
    logic       any_req;
    logic       grant_mem;
    logic       busy;

    always_comb begin
        any_req = bus.ptw_req.valid | bus.mem_req.valid;
`ifdef DBUS_ARB_RR_EN
        // On a tie, MEM wins only if PTW was served last.
        grant_mem = bus.mem_req.valid & (~bus.ptw_req.valid | ~last_served);
`else
        grant_mem = bus.mem_req.valid & ~bus.ptw_req.valid;
`endif
    end

`ifndef DBUS_ARB_RR_EN
    logic unused_last_served;
    assign unused_last_served = last_served;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            latched     <= '0;
            last_served <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        state       <= grant_mem ? BUSY_MEM : BUSY_PTW;
                        latched     <= grant_mem ? bus.mem_req : bus.ptw_req;
                        last_served <= grant_mem;
                    end
                end
                BUSY_PTW, BUSY_MEM: begin
                    if (bus.dresp.data_ok) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state == BUSY_PTW) || (state == BUSY_MEM);

    // The latched copy is replayed until data_ok, even if the owner drops valid.
    always_comb begin
        bus.dreq = '0;
        if (busy) begin
            bus.dreq       = latched;
            bus.dreq.valid = 1'b1;
        end
    end

    assign bus.ptw_resp = (state == BUSY_PTW) ? bus.dresp : '0;
    assign bus.mem_resp = (state == BUSY_MEM) ? bus.dresp : '0;
    assign bus.owner    = state;
endmodule
